// File: rtl/dram_burst_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dram_arb_pkg
//   Shared types and helpers for the DRAM burst arbiter.
//   - arb_state_t : top-level sequencer state (IDLE / XFER / DONE)
//   - byte_incr() : byte-address step between consecutive DRAM words
// ---------------------------------------------------------------------------
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Number of bytes covered by one DRAM word of the given bit width.
  function automatic int unsigned byte_incr(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/dram_burst_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin grant. Searches the request vector starting at
//   the client after last_grant, wrapping around, and returns a one-hot grant
//   for the first requester found (all zeros when nobody requests).
//
// Ports
//   req        in  NUM_CLIENTS    request vector
//   last_grant in  $clog2(N)      index of the most recently served client
//   grant      out NUM_CLIENTS    one-hot grant
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int NUM_CLIENTS = 4,
  localparam int GW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [GW-1:0]          last_grant,
  output logic [NUM_CLIENTS-1:0] grant
);

  logic found;
  int   k;

  always_comb begin
    grant = '0;
    found = 1'b0;
    k     = 0;
    // Offsets 1..N visit every client once, last_grant itself last.
    for (int i = 1; i <= NUM_CLIENTS; i++) begin
      k = int'(last_grant) + i;
      if (k >= NUM_CLIENTS) k = k - NUM_CLIENTS;
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dram_burst_arbiter.sv
// ---------------------------------------------------------------------------
// dram_burst_arbiter
//   Multiplexes NUM_CLIENTS burst requesters onto one Avalon-MM style DRAM
//   master. Grants round-robin at burst granularity, walks each burst word by
//   word under WaitRequest back-pressure, and returns per-client read data,
//   write-advance and completion strobes.
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   client_req[N]                burst request, held until client_done
//   client_we[N]                 1 = write burst, 0 = read burst
//   client_addr[N*AW]            start byte address (word aligned)
//   client_len[N*LW]             burst length in words
//   client_wdata[N*DW]           current write word per client
//   client_rdata[DW]             read data, broadcast to all clients
//   client_rvalid[N]             strobe per accepted read word
//   client_wnext[N]              strobe per accepted write word
//   client_done[N]               burst-complete strobe
//   busy                         high whenever not IDLE
//   DRAM_master_*                Avalon-MM master (Read/Write/Address/
//                                ByteEnable registered, WriteData muxed)
// ---------------------------------------------------------------------------
module dram_burst_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            client_req,
  input  logic [NUM_CLIENTS-1:0]            client_we,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  input  logic [NUM_CLIENTS*LEN_WIDTH-1:0]  client_len,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] client_wdata,
  output logic [DATA_WIDTH-1:0]             client_rdata,
  output logic [NUM_CLIENTS-1:0]            client_rvalid,
  output logic [NUM_CLIENTS-1:0]            client_wnext,
  output logic [NUM_CLIENTS-1:0]            client_done,
  output logic                              busy,
  input  logic                              DRAM_master_WaitRequest,
  output logic                              DRAM_master_Read,
  output logic                              DRAM_master_Write,
  output logic [ADDR_WIDTH-1:0]             DRAM_master_Address,
  output logic [DATA_WIDTH/8-1:0]           DRAM_master_ByteEnable,
  input  logic [DATA_WIDTH-1:0]             DRAM_master_ReadData,
  output logic [DATA_WIDTH-1:0]             DRAM_master_WriteData
);

  localparam int                    GW       = $clog2(NUM_CLIENTS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(byte_incr(DATA_WIDTH));

  arb_state_t             state;
  logic [GW-1:0]          grant_idx;
  logic [GW-1:0]          last_grant;
  logic [GW-1:0]          next_idx;
  logic [NUM_CLIENTS-1:0] grant_oh;
  logic [NUM_CLIENTS-1:0] done_q;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [LEN_WIDTH-1:0]   next_len;
  logic                   we_lat;
  logic                   accept;

  rr_arbiter #(
    .NUM_CLIENTS (NUM_CLIENTS)
  ) u_rr_arbiter (
    .req        (client_req),
    .last_grant (last_grant),
    .grant      (grant_oh)
  );

  always_comb begin
    next_idx = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (grant_oh[i]) next_idx = GW'(i);
    end
  end

  assign next_len = client_len[next_idx*LEN_WIDTH +: LEN_WIDTH];

  // A word moves whenever a command is on the bus and the slave is not stalling.
  assign accept = (state == XFER) && (DRAM_master_Read || DRAM_master_Write) &&
                  !DRAM_master_WaitRequest;

  always_comb begin
    client_rvalid = '0;
    client_wnext  = '0;
    if (accept) begin
      if (we_lat) client_wnext[grant_idx]  = 1'b1;
      else        client_rvalid[grant_idx] = 1'b1;
    end
  end

  assign client_rdata          = DRAM_master_ReadData;
  assign DRAM_master_WriteData = client_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign client_done           = done_q;
  assign busy                  = (state != IDLE);

  // Control sequencer: state, grant bookkeeping and the registered bus outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state                  <= IDLE;
      grant_idx              <= '0;
      last_grant             <= GW'(NUM_CLIENTS - 1);
      done_q                 <= '0;
      DRAM_master_Read       <= 1'b0;
      DRAM_master_Write      <= 1'b0;
      DRAM_master_Address    <= '0;
      DRAM_master_ByteEnable <= '0;
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|client_req) begin
            grant_idx           <= next_idx;
            DRAM_master_Address <= client_addr[next_idx*ADDR_WIDTH +: ADDR_WIDTH];
            if (next_len == '0) begin
              // Empty burst: complete without touching DRAM.
              done_q[next_idx] <= 1'b1;
              state            <= DONE;
            end else begin
              DRAM_master_Read       <= !client_we[next_idx];
              DRAM_master_Write      <= client_we[next_idx];
              DRAM_master_ByteEnable <= '1;
              state                  <= XFER;
            end
          end
        end
        XFER: begin
          if (accept) begin
            DRAM_master_Address <= DRAM_master_Address + ADDR_INC;
            if (remaining == LEN_WIDTH'(1)) begin
              DRAM_master_Read       <= 1'b0;
              DRAM_master_Write      <= 1'b0;
              DRAM_master_ByteEnable <= '0;
              done_q[grant_idx]      <= 1'b1;
              state                  <= DONE;
            end
          end
        end
        DONE: begin
          last_grant <= grant_idx;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Burst descriptor latched at grant; only meaningful while XFER is active.
  always_ff @(posedge clock) begin
    if (state == IDLE && (|client_req)) begin
      we_lat    <= client_we[next_idx];
      remaining <= next_len;
    end else if (accept) begin
      remaining <= remaining - LEN_WIDTH'(1);
    end
  end

endmodule

// File: doc/dram_burst_arbiter.md
# dram_burst_arbiter

Parametrised successor to the accelerator's single-client DRAM master port: multiplexes `NUM_CLIENTS` independent burst requesters onto one Avalon-MM style DRAM master interface. It sits between the controller and processing-unit fetch engines and the external DRAM controller. It arbitrates round-robin at burst granularity, sequences each burst word by word under WaitRequest back-pressure, and returns per-client read data, write-advance and completion strobes.

## Interface
Parameters:
- `NUM_CLIENTS`, 4: number of requesters; must be ≥ 2.
- `DATA_WIDTH`, 32: DRAM word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 32: byte-address width.
- `LEN_WIDTH`, 16: burst length field width, in words.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `client_req`  in  NUM_CLIENTS  burst request, held until `client_done`.
- `client_we`  in  NUM_CLIENTS  1 = write burst, 0 = read burst.
- `client_addr`  in  NUM_CLIENTS×ADDR_WIDTH  start byte address, word-aligned.
- `client_len`  in  NUM_CLIENTS×LEN_WIDTH  word count.
- `client_wdata`  in  NUM_CLIENTS×DATA_WIDTH  current write word.
- `client_rdata`  out  DATA_WIDTH  read data, broadcast to all clients.
- `client_rvalid`  out  NUM_CLIENTS  one-cycle strobe per read word.
- `client_wnext`  out  NUM_CLIENTS  one-cycle strobe when a write word is accepted.
- `client_done`  out  NUM_CLIENTS  one-cycle burst-complete strobe.
- `busy`  out  1  high in any non-IDLE state.
- `DRAM_master_WaitRequest`  in  1  slave stall.
- `DRAM_master_Read`, `DRAM_master_Write`  out  1  registered.
- `DRAM_master_Address`  out  ADDR_WIDTH  registered.
- `DRAM_master_ByteEnable`  out  DATA_WIDTH/8  registered.
- `DRAM_master_ReadData`  in  DATA_WIDTH.
- `DRAM_master_WriteData`  out  DATA_WIDTH  combinational: `client_wdata` of the granted client.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - If any `client_req` is high, grant the first requester after `last_grant`, wrapping around.
  - Latch `addr`, `len` and `we` for the granted client.
  - If `len` = 0, go to DONE with no DRAM access.
  - Otherwise assert `Read` or `Write`, drive `Address` = start address and `ByteEnable` = all ones, and go to XFER.
- XFER, write burst:
  - A word is accepted in a cycle where Read/Write = 1 and WaitRequest = 0.
  - On acceptance, pulse `client_wnext[g]`.
  - The client presents the next word by the following cycle.
- XFER, read burst:
  - A word is accepted under the same condition.
  - On acceptance, pulse `client_rvalid[g]`; `client_rdata` = ReadData in that same cycle.
- XFER, every accepted word: increment the address by DATA_WIDTH/8, modulo 2^ADDR_WIDTH (wrap, no error), and decrement the remaining count.
- XFER, last word accepted: deassert Read/Write, zero ByteEnable, go to DONE.
- DONE:
  - Pulse `client_done[g]`, set `last_grant` = g, return to IDLE.
  - The client drops `client_req` at the clock edge closing the done cycle.
- `client_we` and `client_addr` changes while a burst is in progress are ignored; only the values latched at grant are used.
- Reset values:
  - All outputs 0 and state IDLE.
  - `last_grant` = NUM_CLIENTS−1, so client 0 has first priority.
  - `client_rdata` follows ReadData, and `DRAM_master_WriteData` follows client 0's `client_wdata`.
- Reset mid-burst:
  - Abandon the burst immediately; Read/Write are low in the next cycle.
  - No `client_done` is issued.

## Timing
- Request seen in IDLE at cycle t → Read/Write high from t+1.
- With WaitRequest held at 0, an N-word burst occupies cycles t+1..t+N.
- `client_done` is issued at t+N+1; IDLE is reached at t+N+2, and the next grant can issue at t+N+3.
- `len` = 0: `client_done` at t+1 with no DRAM traffic.
- Each WaitRequest = 1 cycle adds exactly one cycle to the burst. Address, Read/Write and WriteData are held stable while stalled.
- Arbitration is evaluated only in IDLE; requests that arrive mid-burst wait.
- Fairness: with all clients continuously requesting, the grant order is 0,1,…,NUM_CLIENTS−1,0,…

## Structure
- Package `dram_arb_pkg`:
  - State enum `arb_state_t` (IDLE/XFER/DONE).
  - Byte-increment constant function of DATA_WIDTH.
- Sub-module `rr_arbiter`: combinational one-hot grant from `req` and `last_grant`, parametrised by NUM_CLIENTS, instantiated once.

## Test plan
- Client 1 reads len = 4 at 0x100 with WaitRequest = 0 → Address 0x100, 0x104, 0x108, 0x10C on consecutive cycles; four `client_rvalid[1]` pulses carrying the ReadData values; `client_done[1]` one cycle after the last word.
- Client 2 writes len = 3 at 0x200 with WaitRequest high on the 2nd word for 2 cycles → Address and WriteData held for the stall; exactly three `client_wnext[2]` pulses; burst spans 5 cycles.
- All 4 clients request len = 1 from reset → grants in order 0, 1, 2, 3, then 0 again; no client is granted twice before the others.
- Client 3 requests len = 0 → `client_done[3]` at t+1 with Read/Write never asserted.
- Read len = 2 at 0xFFFFFFFC (ADDR_WIDTH = 32) → Address 0xFFFFFFFC, then 0x00000000.
- Reset asserted during word 2 of a len = 8 burst → Read/Write = 0 the next cycle, no `client_done`; after reset, client 0 is granted first.
